// File: rtl/riscv_ifq.sv
// Instruction fetch queue: issues fetch PCs to instruction memory, buffers
// in-order responses paired with their PC, and hands them to decode.
// A redirect discards buffered entries and counts in-flight responses to drop.
module riscv_ifq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [XLEN-1:0] i_PCF,
    output logic            o_stallF,
    input  logic            i_flushD,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_validD,
    input  logic            i_readyD,
    output logic [XLEN-1:0] o_instrD,
    output logic [XLEN-1:0] o_PCD
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    // Pointers wrap modulo 2*DEPTH; the extra bit separates full from empty.
    logic [PW-1:0]   alloc_q, alloc_d;
    logic [PW-1:0]   fill_q,  fill_d;
    logic [PW-1:0]   rd_q,    rd_d;
    logic [PW-1:0]   drop_q,  drop_d;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];

    logic [PW-1:0]   used_c;
    logic [PW-1:0]   inflight_c;
    logic [CW-1:0]   occ_c;
    logic            can_issue_c;
    logic            issue_c;
    logic            keep_c;
    logic            pop_c;
    logic [AW-1:0]   head_idx_c;

    // Occupancy includes responses still owed to us that will be discarded.
    assign used_c      = alloc_q - rd_q;
    assign inflight_c  = alloc_q - fill_q;
    assign occ_c       = {1'b0, used_c} + {1'b0, drop_q};
    assign can_issue_c = occ_c < CW'(DEPTH);

    assign o_imem_req  = can_issue_c & ~i_flushD;
    assign o_imem_addr = i_PCF;
    assign issue_c     = o_imem_req & i_imem_gnt;
    assign o_stallF    = ~i_flushD & ~issue_c;

    assign o_validD    = (fill_q != rd_q);
    assign keep_c      = i_imem_rvalid & ~i_flushD & (drop_q == '0);
    assign pop_c       = o_validD & i_readyD & ~i_flushD;
    assign head_idx_c  = rd_q[AW-1:0];

    assign o_instrD    = o_validD ? instr_mem_q[head_idx_c] : NOP_INSTR;
    assign o_PCD       = o_validD ? pc_mem_q[head_idx_c]    : '0;

    // Pointer and drop-count next state; a flush overrides issue, fill and pop.
    always_comb begin
        alloc_d = alloc_q;
        fill_d  = fill_q;
        rd_d    = rd_q;
        drop_d  = drop_q;
        if (i_flushD) begin
            alloc_d = '0;
            fill_d  = '0;
            rd_d    = '0;
            drop_d  = drop_q + inflight_c - PW'(i_imem_rvalid);
        end else begin
            if (issue_c) begin
                alloc_d = alloc_q + PW'(1);
            end
            if (i_imem_rvalid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - PW'(1);
                end else begin
                    fill_d = fill_q + PW'(1);
                end
            end
            if (pop_c) begin
                rd_d = rd_q + PW'(1);
            end
        end
    end

    // Pointer and drop-count registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            alloc_q <= '0;
            fill_q  <= '0;
            rd_q    <= '0;
            drop_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            rd_q    <= rd_d;
            drop_q  <= drop_d;
        end
    end

    // Entry storage: PC captured at issue, instruction captured at kept response.
    always_ff @(posedge i_clk) begin
        if (issue_c) begin
            pc_mem_q[alloc_q[AW-1:0]] <= i_PCF;
        end
        if (keep_c) begin
            instr_mem_q[fill_q[AW-1:0]] <= i_imem_rdata;
        end
    end

endmodule
